// File: rtl/enigma_stream_cipher.sv
// Two-rotor Enigma engine (rotors I/II, reflector B) with a valid/ready letter stream.
// Rotors step before each valid letter is enciphered; the path is reciprocal from equal start positions.
module enigma_stream_cipher #(
    parameter int unsigned NOTCH_R = 16,
    parameter int unsigned WRAP    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [4:0]  load_pos_r,
    input  logic [4:0]  load_pos_l,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_char,
    output logic        out_err,
    output logic [4:0]  pos_r,
    output logic [4:0]  pos_l,
    output logic [15:0] char_cnt
);

    localparam int unsigned CW   = 5;
    localparam int unsigned SW   = 6;
    localparam int unsigned CNTW = 16;
    localparam int unsigned NL   = 26;

    localparam logic [CW-1:0] ROT_I [0:NL-1] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25,
        5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15,
        5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam logic [CW-1:0] ROT_II [0:NL-1] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,
        5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13,
        5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam logic [CW-1:0] REFL_B [0:NL-1] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23,
        5'd13, 5'd6,  5'd14, 5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25,
        5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Modular helpers: operands are < WRAP, so one conditional subtract folds the 6-bit sum.
    function automatic logic [CW-1:0] add_mod(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return CW'((s >= SW'(WRAP)) ? s - SW'(WRAP) : s);
    endfunction

    function automatic logic [CW-1:0] sub_mod(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(WRAP) - SW'(b);
        return CW'((s >= SW'(WRAP)) ? s - SW'(WRAP) : s);
    endfunction

    function automatic logic [CW-1:0] inv_i(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NL); k++) if (ROT_I[k] == v) r = CW'(k);
        return r;
    endfunction

    function automatic logic [CW-1:0] inv_ii(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NL); k++) if (ROT_II[k] == v) r = CW'(k);
        return r;
    endfunction

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_pos_r, w_pos_r_nxt;
    logic [CW-1:0]   r_pos_l, w_pos_l_nxt;
    logic [CNTW-1:0] r_char_cnt, w_char_cnt_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [CW-1:0]   r_out_char, w_out_char_nxt;
    logic            r_out_err, w_out_err_nxt;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_code_ok;

    logic [CW-1:0]   w_pr_step, w_pl_step;
    logic [CW-1:0]   w_c1, w_c2, w_c3, w_c4, w_cipher;

    // Step first, then encipher with the post-step offsets.
    assign w_pr_step = add_mod(r_pos_r, CW'(1));
    assign w_pl_step = (r_pos_r == CW'(NOTCH_R)) ? add_mod(r_pos_l, CW'(1)) : r_pos_l;
    assign w_c1      = sub_mod(ROT_I[add_mod(in_char, w_pr_step)], w_pr_step);
    assign w_c2      = sub_mod(ROT_II[add_mod(w_c1, w_pl_step)], w_pl_step);
    assign w_c3      = REFL_B[w_c2];
    assign w_c4      = sub_mod(inv_ii(add_mod(w_c3, w_pl_step)), w_pl_step);
    assign w_cipher  = sub_mod(inv_i(add_mod(w_c4, w_pr_step)), w_pr_step);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pos_r     <= '0;
            r_pos_l     <= '0;
            r_char_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_char  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos_r     <= w_pos_r_nxt;
            r_pos_l     <= w_pos_l_nxt;
            r_char_cnt  <= w_char_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_char  <= w_out_char_nxt;
            r_out_err   <= w_out_err_nxt;
        end
    end

    // Load beats a same-cycle input handshake; invalid codes pass through flagged without stepping.
    always_comb begin
        w_state_nxt     = r_state;
        w_pos_r_nxt     = r_pos_r;
        w_pos_l_nxt     = r_pos_l;
        w_char_cnt_nxt  = r_char_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_char_nxt  = r_out_char;
        w_out_err_nxt   = r_out_err;
        w_in_ready      = 1'b0;
        w_code_ok       = in_char < CW'(WRAP);

        case (r_state)
            IDLE:    if (load_en) w_state_nxt = RUN;
            RUN:     w_in_ready = !r_out_valid || out_ready;
            default: w_state_nxt = IDLE;
        endcase

        w_accept = in_valid && w_in_ready && !load_en;

        if (load_en) begin
            w_pos_r_nxt     = (load_pos_r < CW'(WRAP)) ? load_pos_r : '0;
            w_pos_l_nxt     = (load_pos_l < CW'(WRAP)) ? load_pos_l : '0;
            w_char_cnt_nxt  = '0;
            w_out_valid_nxt = 1'b0;
        end else if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            if (w_code_ok) begin
                w_pos_r_nxt    = w_pr_step;
                w_pos_l_nxt    = w_pl_step;
                w_char_cnt_nxt = r_char_cnt + CNTW'(1);
                w_out_char_nxt = w_cipher;
                w_out_err_nxt  = 1'b0;
            end else begin
                w_out_char_nxt = in_char;
                w_out_err_nxt  = 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign out_err   = r_out_err;
    assign pos_r     = r_pos_r;
    assign pos_l     = r_pos_l;
    assign char_cnt  = r_char_cnt;

endmodule

// File: tb/tb_enigma_stream_cipher.sv
// Self-checking bench for enigma_stream_cipher: directed scenarios plus a randomized run
// against a letter-level Enigma model built from the wiring strings.
module tb_enigma_stream_cipher;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_pos_r, load_pos_l;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_char;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_char;
    logic        out_err;
    logic [4:0]  pos_r, pos_l;
    logic [15:0] char_cnt;

    enigma_stream_cipher dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_pos_r (load_pos_r),
        .load_pos_l (load_pos_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .out_err    (out_err),
        .pos_r      (pos_r),
        .pos_l      (pos_l),
        .char_cnt   (char_cnt)
    );

    always #5 clk = ~clk;

    string ROT_I_S  = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    string ROT_II_S = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    string REFL_S   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    int n_pass  = 0;
    int n_total = 0;

    // Model state: machine running, pending output, rotor letters, letter count.
    bit m_run, m_ov, m_oe;
    int m_oc, m_pr, m_pl, m_cnt;
    bit exp_rdy, obs_rdy;

    function automatic int letter(string w, int i);
        return int'(w[i]) - 65;
    endfunction

    function automatic int fwd(string w, int p, int c);
        return (letter(w, (c + p) % 26) - p + 26) % 26;
    endfunction

    function automatic int bwd(string w, int p, int c);
        int idx = 0;
        for (int k = 0; k < 26; k++) if (letter(w, k) == (c + p) % 26) idx = k;
        return (idx - p + 26) % 26;
    endfunction

    function automatic int encipher(int pr, int pl, int c);
        int t;
        t = fwd(ROT_I_S, pr, c);
        t = fwd(ROT_II_S, pl, t);
        t = letter(REFL_S, t);
        t = bwd(ROT_II_S, pl, t);
        return bwd(ROT_I_S, pr, t);
    endfunction

    task automatic model_reset();
        m_run = 0; m_ov = 0; m_oe = 0; m_oc = 0; m_pr = 0; m_pl = 0; m_cnt = 0;
    endtask

    // One clock: drive at the falling edge, advance the model across the rising edge.
    task automatic cycle(input bit ld, input int lr, input int ll,
                         input bit iv, input int ic, input bit ordy);
        int old_pr;
        load_en    = ld;
        load_pos_r = 5'(lr);
        load_pos_l = 5'(ll);
        in_valid   = iv;
        in_char    = 5'(ic);
        out_ready  = ordy;
        #1;
        obs_rdy = in_ready;
        exp_rdy = m_run && (!m_ov || ordy);
        @(posedge clk);
        if (ld) begin
            m_run = 1;
            m_pr  = (lr < 26) ? lr : 0;
            m_pl  = (ll < 26) ? ll : 0;
            m_cnt = 0;
            m_ov  = 0;
        end else if (iv && exp_rdy) begin
            m_ov = 1;
            if (ic < 26) begin
                old_pr = m_pr;
                m_pr   = (m_pr + 1) % 26;
                if (old_pr == 16) m_pl = (m_pl + 1) % 26;
                m_oc  = encipher(m_pr, m_pl, ic);
                m_oe  = 0;
                m_cnt = (m_cnt + 1) % 65536;
            end else begin
                m_oc = ic;
                m_oe = 1;
            end
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 0; load_pos_r = 0; load_pos_l = 0;
        in_valid = 0; in_char = 0; out_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if ({out_valid, out_char, out_err, in_ready, pos_r, pos_l, char_cnt} !== 34'd0)
            $display("FAIL reset_state: got ov=%b oc=%0d oe=%b rdy=%b pr=%0d pl=%0d cnt=%0d want all 0",
                     out_valid, out_char, out_err, in_ready, pos_r, pos_l, char_cnt);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 5 + i, 1);
            n_total++;
            if (obs_rdy !== 1'b0 || out_valid !== 1'b0 || pos_r !== 5'd0 || pos_l !== 5'd0)
                $display("FAIL idle_ignores_input: rdy=%b ov=%b pr=%0d pl=%0d want 0 0 0 0",
                         obs_rdy, out_valid, pos_r, pos_l);
            else n_pass++;
        end
    endtask

    task automatic test_known_letter();
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 1);
        n_total++;
        if (obs_rdy !== 1'b1) $display("FAIL known_ready: got %b want 1", obs_rdy);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || out_char !== 5'd14 || out_err !== 1'b0 ||
            pos_r !== 5'd1 || pos_l !== 5'd0 || char_cnt !== 16'd1)
            $display("FAIL known_A_to_O: ov=%b oc=%0d oe=%b pr=%0d pl=%0d cnt=%0d want 1 14 0 1 0 1",
                     out_valid, out_char, out_err, pos_r, pos_l, char_cnt);
        else n_pass++;
        cycle(0, 0, 0, 0, 0, 1);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL known_drain: out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 14, 1);
        n_total++;
        if (out_valid !== 1'b1 || out_char !== 5'd0)
            $display("FAIL reciprocity: ov=%b oc=%0d want 1 0", out_valid, out_char);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            cycle(0, 0, 0, 1, c, 1);
            n_total++;
            if (obs_rdy !== 1'b1 || out_valid !== 1'b1 || out_char !== 5'(m_oc) ||
                char_cnt !== 16'(m_cnt))
                $display("FAIL stream_%0d: rdy=%b ov=%b oc=%0d cnt=%0d want 1 1 %0d %0d",
                         c, obs_rdy, out_valid, out_char, char_cnt, m_oc, m_cnt);
            else n_pass++;
        end
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_stepping();
        cycle(1, 16, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, $urandom_range(0, 25), 1);
        n_total++;
        if (pos_r !== 5'd17 || pos_l !== 5'd1 || out_char !== 5'(m_oc))
            $display("FAIL notch_step: pr=%0d pl=%0d oc=%0d want 17 1 %0d", pos_r, pos_l, out_char, m_oc);
        else n_pass++;
        cycle(1, 25, 25, 0, 0, 1);
        cycle(0, 0, 0, 1, $urandom_range(0, 25), 1);
        n_total++;
        if (pos_r !== 5'd0 || pos_l !== 5'd25 || out_char !== 5'(m_oc))
            $display("FAIL right_wrap: pr=%0d pl=%0d oc=%0d want 0 25 %0d", pos_r, pos_l, out_char, m_oc);
        else n_pass++;
        cycle(1, 16, 25, 0, 0, 1);
        cycle(0, 0, 0, 1, 7, 1);
        n_total++;
        if (pos_r !== 5'd17 || pos_l !== 5'd0 || out_char !== 5'(m_oc))
            $display("FAIL left_wrap: pr=%0d pl=%0d oc=%0d want 17 0 %0d", pos_r, pos_l, out_char, m_oc);
        else n_pass++;
        cycle(1, 30, 27, 0, 0, 1);
        n_total++;
        if (pos_r !== 5'd0 || pos_l !== 5'd0 || char_cnt !== 16'd0)
            $display("FAIL bad_load: pr=%0d pl=%0d cnt=%0d want 0 0 0", pos_r, pos_l, char_cnt);
        else n_pass++;
    endtask

    task automatic test_invalid();
        cycle(1, 3, 4, 0, 0, 1);
        cycle(0, 0, 0, 1, 2, 1);
        cycle(0, 0, 0, 1, 30, 1);
        n_total++;
        if (out_valid !== 1'b1 || out_char !== 5'd30 || out_err !== 1'b1 ||
            pos_r !== 5'd4 || pos_l !== 5'd4 || char_cnt !== 16'd1)
            $display("FAIL invalid_code: ov=%b oc=%0d oe=%b pr=%0d pl=%0d cnt=%0d want 1 30 1 4 4 1",
                     out_valid, out_char, out_err, pos_r, pos_l, char_cnt);
        else n_pass++;
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_stall();
        int first;
        cycle(1, 5, 7, 0, 0, 0);
        cycle(0, 0, 0, 1, 11, 0);
        first = m_oc;
        n_total++;
        if (out_valid !== 1'b1 || out_char !== 5'(first))
            $display("FAIL stall_first: ov=%b oc=%0d want 1 %0d", out_valid, out_char, first);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 1, 12 + i, 0);
            n_total++;
            if (obs_rdy !== 1'b0 || out_valid !== 1'b1 || out_char !== 5'(first) ||
                pos_r !== 5'd6 || char_cnt !== 16'd1)
                $display("FAIL stall_hold_%0d: rdy=%b ov=%b oc=%0d pr=%0d cnt=%0d want 0 1 %0d 6 1",
                         i, obs_rdy, out_valid, out_char, pos_r, char_cnt, first);
            else n_pass++;
        end
        cycle(1, 9, 9, 1, 3, 0);
        n_total++;
        if (out_valid !== 1'b0 || pos_r !== 5'd9 || char_cnt !== 16'd0)
            $display("FAIL load_flush: ov=%b pr=%0d cnt=%0d want 0 9 0", out_valid, pos_r, char_cnt);
        else n_pass++;
        cycle(0, 0, 0, 1, 4, 0);
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || pos_r !== 5'd0 || char_cnt !== 16'd0)
            $display("FAIL async_reset: ov=%b rdy=%b pr=%0d cnt=%0d want 0 0 0 0",
                     out_valid, in_ready, pos_r, char_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(0, 0, 0, 1, 4, 1);
        n_total++;
        if (obs_rdy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL needs_reload: rdy=%b ov=%b want 0 0", obs_rdy, out_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ld, iv, ordy;
        int ic;
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            ld   = (i == 0) || ($urandom_range(0, 39) == 0);
            iv   = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 2) != 0;
            ic   = ($urandom_range(0, 9) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            cycle(ld, $urandom_range(0, 31), $urandom_range(0, 31), iv, ic, ordy);
            n_total++;
            if (obs_rdy !== exp_rdy || out_valid !== m_ov ||
                (m_ov && (out_char !== 5'(m_oc) || out_err !== m_oe)) ||
                pos_r !== 5'(m_pr) || pos_l !== 5'(m_pl) || char_cnt !== 16'(m_cnt)) begin
                if (errs < 10)
                    $display("FAIL random_%0d: rdy=%b ov=%b oc=%0d oe=%b pr=%0d pl=%0d cnt=%0d want %b %b %0d %b %0d %0d %0d",
                             i, obs_rdy, out_valid, out_char, out_err, pos_r, pos_l, char_cnt,
                             exp_rdy, m_ov, m_oc, m_oe, m_pr, m_pl, m_cnt);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_known_letter();
        test_back_to_back();
        test_stepping();
        test_invalid();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
